// File: rtl/alu_compare_arbiter_if.sv
// Request/response bundle between the two compare requesters (branch unit,
// crypto accelerator) and the shared magnitude-compare arbiter.
interface alu_compare_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid, req1_valid;
  logic                  req0_ready, req1_ready;
  logic [DATA_WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic                  req0_unsigned, req1_unsigned;
  logic                  rsp0_valid, rsp1_valid;
  logic                  rsp0_ready, rsp1_ready;
  logic                  rsp_eq, rsp_lt, rsp_gt;
  logic                  busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_unsigned, req1_unsigned, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_eq, rsp_lt, rsp_gt, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_unsigned, req1_unsigned, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_eq, rsp_lt, rsp_gt, busy
  );
endinterface

// File: rtl/alu_compare_arbiter.sv
// Round-robin arbiter sharing one signed/unsigned magnitude comparator between two ports.
// CMP_FAST_PATH_EN: compare at the accept edge, skipping the COMPARE state (latency 1).
module alu_compare_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_compare_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifndef CMP_FAST_PATH_EN
    COMPARE = 2'd1,
`endif
    RESP    = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  uns;
    logic                  port;
  } req_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } flags_t;

  // Extra sign bit on the difference keeps the subtraction overflow-free.
  function automatic flags_t cmp_flags(input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b,
                                       input logic                  uns);
    logic [DATA_WIDTH:0]   ae, be;
    logic [DATA_WIDTH+1:0] diff;
    flags_t                f;
    ae   = {~uns & a[DATA_WIDTH-1], a};
    be   = {~uns & b[DATA_WIDTH-1], b};
    diff = {ae[DATA_WIDTH], ae} - {be[DATA_WIDTH], be};
    f.eq = (ae == be);
    f.lt = diff[DATA_WIDTH+1];
    f.gt = !f.eq && !f.lt;
    return f;
  endfunction

  state_t      state, state_d;
  logic        last_grant;
  logic [1:0]  rsp_vld_q, rsp_vld_d;
  flags_t      flags_q;
  logic        idle, grant0, grant1, accept, sel, rsp_hs;
  req_t        sel_req;

  assign idle   = (state == IDLE);
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

  assign bus.req0_ready = idle && grant0;
  assign bus.req1_ready = idle && grant1;

  assign accept = (bus.req0_valid && bus.req0_ready) ||
                  (bus.req1_valid && bus.req1_ready);
  assign sel    = bus.req1_ready;
  assign rsp_hs = (rsp_vld_q[0] && bus.rsp0_ready) ||
                  (rsp_vld_q[1] && bus.rsp1_ready);

  always_comb begin
    sel_req      = '0;
    sel_req.port = sel;
    if (sel) begin
      sel_req.a   = bus.req1_a;
      sel_req.b   = bus.req1_b;
      sel_req.uns = bus.req1_unsigned;
    end else begin
      sel_req.a   = bus.req0_a;
      sel_req.b   = bus.req0_b;
      sel_req.uns = bus.req0_unsigned;
    end
  end

`ifndef CMP_FAST_PATH_EN
  req_t req_q;
`endif

  always_comb begin
    state_d   = state;
    rsp_vld_d = rsp_vld_q;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef CMP_FAST_PATH_EN
          state_d        = RESP;
          rsp_vld_d[sel] = 1'b1;
`else
          state_d        = COMPARE;
`endif
        end
      end
`ifndef CMP_FAST_PATH_EN
      COMPARE: begin
        state_d               = RESP;
        rsp_vld_d[req_q.port] = 1'b1;
      end
`endif
      RESP: begin
        if (rsp_hs) begin
          state_d   = IDLE;
          rsp_vld_d = 2'b00;
        end
      end
      default: begin
        state_d   = IDLE;
        rsp_vld_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_vld_q  <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      state     <= state_d;
      rsp_vld_q <= rsp_vld_d;
      if (accept) last_grant <= sel;
    end
  end

`ifdef CMP_FAST_PATH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      flags_q <= '0;
    else if (accept) flags_q <= cmp_flags(sel_req.a, sel_req.b, sel_req.uns);
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept)            req_q   <= sel_req;
      if (state == COMPARE)  flags_q <= cmp_flags(req_q.a, req_q.b, req_q.uns);
    end
  end
`endif

  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp_eq     = flags_q.eq;
  assign bus.rsp_lt     = flags_q.lt;
  assign bus.rsp_gt     = flags_q.gt;
  assign bus.busy       = !idle;

endmodule

// File: tb/tb_alu_compare_arbiter.sv
// Directed bench for alu_compare_arbiter: vector table plus hand-written
// contention, back-pressure and mid-operation reset sequences.
module tb_alu_compare_arbiter;

`ifdef CMP_FAST_PATH_EN
  localparam int LAT   = 1;
  localparam int ISSUE = 2;
`else
  localparam int LAT   = 2;
  localparam int ISSUE = 3;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_compare_arbiter_if #(.DATA_WIDTH(32)) bus ();

  alu_compare_arbiter #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic        eq;
    logic        lt;
    logic        gt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input logic p);
    return p ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rv(input logic p);
    return p ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic uns);
    if (p) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_unsigned = uns;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_unsigned = uns;
    end
  endtask

  task automatic set_rsp_ready(input logic p, input logic r);
    if (p) bus.rsp1_ready = r;
    else   bus.rsp0_ready = r;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rsp0_valid"}, bus.rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, bus.rsp1_valid, 0);
    chk({tag, "_flags"}, {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    @(posedge clk); #1;
    set_req(v.port, 1'b1, v.a, v.b, v.uns);
    n = 0;
    @(negedge clk);
    while (!rdy(v.port) && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("v%0d_req_ready", idx), rdy(v.port), 1);
    @(posedge clk); #1;
    set_req(v.port, 1'b0, 32'h0, 32'h0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rv(v.port) && n < 10);
    chk($sformatf("v%0d_latency", idx), n, LAT);
    chk($sformatf("v%0d_flags", idx), {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, {v.eq, v.lt, v.gt});
    chk($sformatf("v%0d_other_rsp", idx), rv(!v.port), 0);
    @(posedge clk); #1;
    set_rsp_ready(v.port, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(v.port, 1'b0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_drop", idx), rv(v.port), 0);
  endtask

  task automatic release_and_quiet(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_no_stale_rsp"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ng, last_cyc;
    logic gp;

    vecs[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_ready", {bus.req0_ready, bus.req1_ready}, 0);
    rst_n = 1'b1;

    // Continuous contention from reset: grants alternate starting with port 0.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
    set_req(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    ng = 0;
    last_cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        gp = bus.req1_ready;
        chk("cont_one_ready", bus.req0_ready && bus.req1_ready, 0);
        chk("cont_grant_port", gp, ng % 2);
        if (ng > 0) chk("cont_interval", c - last_cyc, ISSUE);
        last_cyc = c;
        ng++;
      end
      if (bus.rsp0_valid || bus.rsp1_valid)
        chk("cont_flags", {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, 3'b100);
      @(posedge clk);
    end
    chk("cont_grant_count", ng, (20 + ISSUE - 1) / ISSUE);
    #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Back-pressure on port 0 while port 1 waits.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'd5, 32'd9, 1'b0);
    @(negedge clk);
    chk("hold_req0_ready", bus.req0_ready, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b1, 32'd10, 32'd10, 1'b1);
    n = 0;
    do begin
      @(negedge clk); n++;
      chk("hold_req1_blocked", bus.req1_ready, 0);
    end while (!bus.rsp0_valid && n < 10);
    chk("hold_latency", n, LAT);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp0_valid", bus.rsp0_valid, 1);
      chk("hold_flags", {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, 3'b010);
      chk("hold_req1_ready", bus.req1_ready, 0);
      chk("hold_rsp1_valid", bus.rsp1_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_req1_ready", bus.req1_ready, 0);
    chk("hs_cycle_rsp0_valid", bus.rsp0_valid, 1);
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    @(negedge clk);
    chk("after_hs_req1_ready", bus.req1_ready, 1);
    chk("after_hs_rsp0_valid", bus.rsp0_valid, 0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp1_valid && n < 10);
    chk("p1_after_hold_latency", n, LAT);
    chk("p1_after_hold_flags", {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, 3'b100);
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b0;

    // Reset one cycle after accept (COMPARE in the default build).
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    @(negedge clk);
    chk("rstc_req1_ready", bus.req1_ready, 1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rstc_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rstc");
    release_and_quiet("rstc");

    // Reset while a port 0 response is pending.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    @(negedge clk);
    chk("rstr_req0_ready", bus.req0_ready, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp0_valid && n < 10);
    chk("rstr_rsp0_valid", bus.rsp0_valid, 1);
    chk("rstr_flags", {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, 3'b010);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rstr");
    release_and_quiet("rstr");

    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'd1, 32'd2, 1'b1);
    set_req(1'b1, 1'b1, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    chk("post_rst_grant0", bus.req0_ready, 1);
    chk("post_rst_grant1", bus.req1_ready, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.rsp0_ready = 1'b1;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
